// File: rtl/param_booth_multiplier.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, fixed latency WIDTH/2+1.
// Optional feature macro MULT_ACC_EN adds an acc port that adds the product into out.
module param_booth_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
`ifdef MULT_ACC_EN
  input  logic               acc,
`endif
  output logic [2*WIDTH-1:0] out,
  output logic               ready
);

  localparam int PW = 2*WIDTH;
  localparam int N  = WIDTH/2 + 1;
  localparam int CW = $clog2(N);
  localparam int BW = WIDTH + 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  // Partial sums are kept modulo 2^(2*WIDTH): bits above the product width
  // can never influence the truncated result, so no guard bits are stored.
  logic signed [PW-1:0] a_p0;
  logic signed [PW-1:0] psum_p0;
  logic signed [PW-1:0] psum_next;
  logic [BW-1:0]        b_p0;
  logic [CW-1:0]        cnt_p0;
  logic                 accept;
  logic                 last;
  logic                 add_prev;
`ifdef MULT_ACC_EN
  logic                 acc_p0;
`endif

  function automatic logic signed [PW-1:0] booth_pp(input logic [2:0] t,
                                                    input logic signed [PW-1:0] a);
    case (t)
      3'b001, 3'b010: return a;
      3'b011:         return a <<< 1;
      3'b100:         return -(a <<< 1);
      3'b101, 3'b110: return -a;
      default:        return '0;
    endcase
  endfunction

  function automatic logic [PW-1:0] wrap_result(input logic [PW-1:0] prev,
                                                input logic [PW-1:0] prod,
                                                input logic add);
    return add ? prev + prod : prod;
  endfunction

  assign ready  = (state != RUN);
  assign accept = start && ready;
  assign last   = (cnt_p0 == CW'(N-1));
`ifdef MULT_ACC_EN
  assign add_prev = acc_p0;
`else
  assign add_prev = 1'b0;
`endif

  always_comb begin
    psum_next = psum_p0 + booth_pp(b_p0[2:0], a_p0);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (accept) state_next = RUN;
      RUN:        if (last)   state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Stage p0: latch operands on accept, then retire one digit per RUN edge
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0    <= '0;
      b_p0    <= '0;
      psum_p0 <= '0;
      cnt_p0  <= '0;
      out     <= '0;
`ifdef MULT_ACC_EN
      acc_p0  <= 1'b0;
`endif
    end else if (accept) begin
      a_p0    <= {{(PW-WIDTH){signed_mode & ina[WIDTH-1]}}, ina};
      b_p0    <= {{2{signed_mode & inb[WIDTH-1]}}, inb, 1'b0};
      psum_p0 <= '0;
      cnt_p0  <= '0;
`ifdef MULT_ACC_EN
      acc_p0  <= acc;
`endif
    end else if (state == RUN) begin
      psum_p0 <= psum_next;
      a_p0    <= a_p0 <<< 2;
      b_p0    <= b_p0 >> 2;
      cnt_p0  <= cnt_p0 + CW'(1);
      if (last) out <= wrap_result(out, psum_next, add_prev);
    end
  end

endmodule

// File: tb/tb_param_booth_multiplier.sv
// Scoreboard bench for param_booth_multiplier: random and directed products against an arithmetic model.
module tb_param_booth_multiplier;
  localparam int W = 8;
  localparam int LAT = W/2 + 1;
`ifdef MULT_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed_mode = 1'b0;
  logic [W-1:0] ina = '0;
  logic [W-1:0] inb = '0;
  logic acc_in = 1'b0;
  logic [2*W-1:0] out;
  logic ready;

  int checks = 0;
  int passed = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] model_out = '0;
  logic prev_ready = 1'b1;

  param_booth_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .ina(ina), .inb(inb),
`ifdef MULT_ACC_EN
    .acc(acc_in),
`endif
    .out(out), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sm);
    longint pa, pb, p;
    pa = sm ? longint'($signed(a)) : longint'(a);
    pb = sm ? longint'($signed(b)) : longint'(b);
    p = pa * pb;
    return p[2*W-1:0];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every rising ready outside reset presents one result
  always @(negedge clk) begin
    if (rst) prev_ready = 1'b1;
    else begin
      if (ready && !prev_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 64'(out), 64'hDEAD_0000);
        else chk("product", 64'(out), 64'(sb.pop_front()));
      end
      prev_ready = ready;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_out = '0;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sm, input logic ac);
    logic [2*W-1:0] exp, held;
    int cnt;
    ina = a; inb = b; signed_mode = sm; acc_in = ac; start = 1'b1;
    exp = ref_mul(a, b, sm);
    if (ACC_EN && ac) exp = model_out + exp;
    held = model_out;
    model_out = exp;
    sb.push_back(exp);
    tick();
    start = 1'b0;
    cnt = 0;
    while (!ready && cnt < 20) begin
      ina = W'($urandom); inb = W'($urandom); signed_mode = 1'($urandom);
      if (cnt == 2) chk("held_during_run", 64'(out), 64'(held));
      cnt++;
      tick();
    end
    chk("latency", 64'(cnt), 64'(LAT));
  endtask

  initial begin
    int cnt;
    tick();
    tick();
    chk("reset_out", 64'(out), 64'd0);
    chk("reset_ready", 64'(ready), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 19) begin
        chk("idle_out", 64'(out), 64'd0);
        chk("idle_ready", 64'(ready), 64'd1);
      end
    end

    do_op(8'd255, 8'd255, 1'b0, 1'b0);
    chk("unsigned_max", 64'(out), 64'd65025);
    do_op(8'h80, 8'h80, 1'b1, 1'b0);
    chk("signed_min_sq", 64'(out), 64'd16384);
    do_op(8'hF9, 8'd9, 1'b1, 1'b0);
    chk("signed_neg", 64'(out), 64'hFFC1);

    // Start pulse while busy must be ignored
    ina = 8'd3; inb = 8'd7; signed_mode = 1'b0; acc_in = 1'b0; start = 1'b1;
    sb.push_back(16'd21);
    model_out = 16'd21;
    tick();
    start = 1'b0;
    tick();
    ina = 8'd5; inb = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (!ready && cnt < 20) begin cnt++; tick(); end
    chk("busy_start_ignored", 64'(out), 64'd21);
    for (int i = 0; i < 8; i++) tick();
    chk("no_second_op", 64'(ready), 64'd1);

    // Reset on the third RUN edge aborts the operation
    ina = 8'd100; inb = 8'd100; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_out", 64'(out), 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    rst = 1'b0;
    model_out = '0;
    for (int i = 0; i < 10; i++) tick();
    chk("abort_no_result", 64'(out), 64'd0);

    if (ACC_EN) begin
      do_op(8'd3, 8'd4, 1'b0, 1'b0);
      chk("acc_first", 64'(out), 64'd12);
      do_op(8'd5, 8'd6, 1'b0, 1'b1);
      chk("acc_add", 64'(out), 64'd42);
      do_reset();
      do_op(8'd255, 8'd255, 1'b0, 1'b1);
      chk("acc_wrap1", 64'(out), 64'd65025);
      do_op(8'd255, 8'd255, 1'b0, 1'b1);
      chk("acc_wrap2", 64'(out), 64'd64514);
    end

    for (int i = 0; i < 1000; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), ACC_EN ? 1'($urandom) : 1'b0);

    cnt = 0;
    while (sb.size() != 0 && cnt < 20) begin cnt++; tick(); end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
